// File: rtl/imem_responder.sv
// Instruction-memory responder: word-addressed fetch port with fixed read latency,
// a first-word-fall-through response FIFO, credit-based flow control, load port and flush.
module imem_responder #(
    parameter int DEPTH     = 1024,
    parameter int LATENCY   = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    input  logic        flush,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    output logic [3:0]  outstanding
);
    localparam int          AW      = $clog2(DEPTH);
    localparam int          PW      = $clog2(RSP_DEPTH);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam logic [3:0]  CREDIT  = 4'(RSP_DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

    logic [31:0]        mem_q [DEPTH];
    logic [LATENCY-1:0] pv_q, pv_d;
    logic [31:0]        pd_q [LATENCY];
    logic               pe_q [LATENCY];
    logic [31:0]        fd_q [RSP_DEPTH];
    logic               fe_q [RSP_DEPTH];
    logic [PW:0]        wr_q, wr_d, rd_q, rd_d;
    logic [3:0]         out_q, out_d;

    logic        accept, pop, push, empty;
    logic        req_in_range;
    logic [31:0] rd_word;

    assign req_in_range = (req_addr < DEPTH_W);
    assign rd_word      = req_in_range ? mem_q[req_addr[AW-1:0]] : '0;

    assign empty       = (wr_q == rd_q);
    assign rsp_valid   = !empty;
    assign rsp_data    = empty ? '0 : fd_q[rd_q[PW-1:0]];
    assign rsp_err     = empty ? 1'b0 : fe_q[rd_q[PW-1:0]];
    assign outstanding = out_q;

    // Credit counts everything in flight, so the FIFO always has room when a word arrives.
    assign req_ready = !rst && !flush && !ld_en && (out_q < CREDIT);
    assign accept    = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready && !flush;
    assign push      = pv_q[LATENCY-1] && !flush;

    always_comb begin
        pv_d = '0;
        for (int i = 1; i < LATENCY; i++) begin
            pv_d[i] = pv_q[i-1];
        end
        pv_d[0] = accept;
        wr_d    = wr_q;
        rd_d    = rd_q;
        out_d   = out_q;
        if (flush) begin
            pv_d  = '0;
            wr_d  = '0;
            rd_d  = '0;
            out_d = '0;
        end else begin
            if (push) wr_d = wr_q + PTR_ONE;
            if (pop)  rd_d = rd_q + PTR_ONE;
            if (accept && !pop)      out_d = out_q + 4'd1;
            else if (!accept && pop) out_d = out_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv_q  <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            out_q <= '0;
        end else begin
            pv_q  <= pv_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            out_q <= out_d;
        end
    end

    // Datapath storage carries no reset; validity is tracked by the bits above.
    always_ff @(posedge clk) begin
        for (int i = LATENCY-1; i > 0; i--) begin
            pd_q[i] <= pd_q[i-1];
            pe_q[i] <= pe_q[i-1];
        end
        pd_q[0] <= rd_word;
        pe_q[0] <= !req_in_range;
        if (push) begin
            fd_q[wr_q[PW-1:0]] <= pd_q[LATENCY-1];
            fe_q[wr_q[PW-1:0]] <= pe_q[LATENCY-1];
        end
    end

    always_ff @(posedge clk) begin
        if (ld_en && (ld_addr < DEPTH_W)) begin
            mem_q[ld_addr[AW-1:0]] <= ld_data;
        end
    end

endmodule
